sad: RTL and testbench



---
 rtl/sad.sv | 118 +++++++++++
 tb/tb_sad.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sad.sv
// Sum-of-absolute-differences engine: 128 blocks of 256 byte pairs,
// one 32-bit result per block written to the result SRAM.
module sad (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Go,
  output logic [14:0] A_Addr,
  input  logic [7:0]  A_Data,
  output logic [14:0] B_Addr,
  input  logic [7:0]  B_Data,
  output logic [6:0]  C_Addr,
  output logic        I_RW,
  output logic        I_En,
  output logic        O_RW,
  output logic        O_En,
  output logic        Done,
  output logic [31:0] SAD_Out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [14:0] r_addr;
  logic [6:0]  r_c_addr;
  logic        r_i_en;
  logic        r_o_en;
  logic        r_o_rw;
  logic        r_done;
  logic        r_valid;
  logic [31:0] r_sum;

  logic [8:0]  w_diff;
  logic [8:0]  w_neg;
  logic [7:0]  w_mag;
  logic [31:0] w_acc;

  // 9-bit signed difference, magnitude always fits in 8 bits
  assign w_diff = {1'b0, A_Data} - {1'b0, B_Data};
  assign w_neg  = -w_diff;
  assign w_mag  = w_diff[8] ? w_neg[7:0] : w_diff[7:0];
  assign w_acc  = r_sum + {24'd0, w_mag};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_c_addr <= '0;
      r_i_en   <= 1'b0;
      r_o_en   <= 1'b0;
      r_o_rw   <= 1'b1;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (Go) begin
            r_state <= S_READ;
            r_addr  <= '0;
            r_i_en  <= 1'b1;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_sum   <= '0;
          end
        end
        S_READ: begin
          r_valid <= 1'b1;
          if (r_valid) r_sum <= w_acc;
          if (r_addr[7:0] == 8'hFF) begin
            r_state <= S_DRAIN;
            r_i_en  <= 1'b0;
          end else begin
            r_addr <= r_addr + 15'd1;
          end
        end
        S_DRAIN: begin
          r_sum    <= w_acc;
          r_state  <= S_WRITE;
          r_o_en   <= 1'b1;
          r_o_rw   <= 1'b0;
          r_c_addr <= r_addr[14:8];
        end
        S_WRITE: begin
          r_o_en <= 1'b0;
          r_o_rw <= 1'b1;
          if (r_addr[14:8] == 7'd127) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_READ;
            r_addr  <= {r_addr[14:8] + 7'd1, 8'd0};
            r_i_en  <= 1'b1;
            r_valid <= 1'b0;
            r_sum   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A_Addr  = r_addr;
  assign B_Addr  = r_addr;
  assign C_Addr  = r_c_addr;
  assign I_RW    = 1'b1;
  assign I_En    = r_i_en;
  assign O_RW    = r_o_rw;
  assign O_En    = r_o_en;
  assign Done    = r_done;
  assign SAD_Out = r_sum;

endmodule

// File: tb/tb_sad.sv
// Bench for sad: SRAM models, pattern table per block range,
// random data against a per-block reference sum.
module tb_sad;

  logic        Clk;
  logic        Rst;
  logic        Go;
  logic [14:0] A_Addr;
  logic [7:0]  A_Data;
  logic [14:0] B_Addr;
  logic [7:0]  B_Data;
  logic [6:0]  C_Addr;
  logic        I_RW;
  logic        I_En;
  logic        O_RW;
  logic        O_En;
  logic        Done;
  logic [31:0] SAD_Out;

  sad dut (
    .Clk(Clk), .Rst(Rst), .Go(Go),
    .A_Addr(A_Addr), .A_Data(A_Data),
    .B_Addr(B_Addr), .B_Data(B_Data),
    .C_Addr(C_Addr), .I_RW(I_RW), .I_En(I_En),
    .O_RW(O_RW), .O_En(O_En), .Done(Done),
    .SAD_Out(SAD_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0]  memA [32768];
  logic [7:0]  memB [32768];
  logic [31:0] memC [128];
  int          memC_gen [128];
  int          gen;
  int          wr_cnt;
  bit          addr_bad;

  initial begin
    wr_cnt   = 0;
    addr_bad = 0;
    gen      = 0;
    A_Data   = 8'd0;
    B_Data   = 8'd0;
    for (int i = 0; i < 128; i++) memC_gen[i] = -1;
  end

  always @(posedge Clk) begin
    if (I_En && I_RW) begin
      A_Data <= memA[A_Addr];
      B_Data <= memB[B_Addr];
    end
    if (O_En && !O_RW) begin
      memC[C_Addr]     <= SAD_Out;
      memC_gen[C_Addr] <= gen;
      wr_cnt           <= wr_cnt + 1;
    end
    if (A_Addr != B_Addr) addr_bad <= 1'b1;
  end

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer sum of |a-b| over one block
  function automatic int ref_sad(input int blk);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < 256; i++) begin
      d = int'(memA[blk*256+i]) - int'(memB[blk*256+i]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  typedef struct {
    int          first;
    int          last;
    int          amode;
    int          bmode;
    bit          fixed;
    logic [31:0] exp;
  } vec_t;

  // modes: 0 random, 1 0xFF, 2 0x00, 3 ramp, 4 copy of A
  function automatic logic [7:0] pat(input int mode, input int i,
                                     input logic [7:0] a);
    case (mode)
      1: return 8'hFF;
      2: return 8'h00;
      3: return i[7:0];
      4: return a;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  vec_t tbl [5];

  task automatic pulse_go();
    @(negedge Clk);
    Go = 1'b1;
    @(posedge Clk);
    #1 Go = 1'b0;
  endtask

  task automatic run_full(input bit busy, output int cyc);
    int n;
    int w0;
    w0 = wr_cnt;
    gen++;
    pulse_go();
    n = 0;
    while (!Done && n < 40000) begin
      @(posedge Clk);
      n++;
      #1;
      if (busy && n == 5*258 + 100) Go = 1'b1;
      if (busy && n == 5*258 + 101) Go = 1'b0;
    end
    cyc = n + 1;
    if (!Done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got 0 after %0d cycles", n);
    end
    chk("write_count", 64'(wr_cnt - w0), 64'd128);
  endtask

  task automatic chk_results(input bit use_tbl);
    logic [31:0] e;
    for (int b = 0; b < 128; b++) begin
      e = 32'(ref_sad(b));
      if (use_tbl)
        for (int t = 0; t < 5; t++)
          if (tbl[t].fixed && b >= tbl[t].first && b <= tbl[t].last)
            e = tbl[t].exp;
      chk($sformatf("result_blk%0d", b), 64'(memC[b]), 64'(e));
      chk($sformatf("written_blk%0d", b), 64'(memC_gen[b]), 64'(gen));
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, {Done, O_En, I_En, I_RW, O_RW, A_Addr, B_Addr, C_Addr,
             SAD_Out},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 15'd0, 15'd0, 7'd0, 32'd0});
  endtask

  int cyc;
  int n;
  int w0;

  initial begin
    checks   = 0;
    failures = 0;
    Go       = 1'b0;
    Rst      = 1'b0;
    tbl[0] = '{0,   15,  0, 4, 1'b1, 32'h0000_0000};
    tbl[1] = '{16,  31,  1, 2, 1'b1, 32'h0000_FF00};
    tbl[2] = '{32,  47,  2, 1, 1'b1, 32'h0000_FF00};
    tbl[3] = '{48,  63,  3, 2, 1'b1, 32'h0000_7F80};
    tbl[4] = '{64,  127, 0, 0, 1'b0, 32'h0};
    repeat (3) @(posedge Clk);
    #1 chk_reset_vals("reset_values");
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 chk_reset_vals("idle_values");

    for (int t = 0; t < 5; t++)
      for (int b = tbl[t].first; b <= tbl[t].last; b++)
        for (int i = 0; i < 256; i++) begin
          memA[b*256+i] = pat(tbl[t].amode, i, 8'd0);
          memB[b*256+i] = pat(tbl[t].bmode, i, memA[b*256+i]);
        end

    run_full(1'b1, cyc);
    chk("done_cycle_busy_go", 64'(cyc), 64'd33025);
    chk_results(1'b1);
    repeat (20) @(posedge Clk);
    #1 chk("done_holds", 64'(Done), 64'd1);

    for (int i = 0; i < 32768; i++) begin
      memA[i] = 8'($urandom_range(0, 255));
      memB[i] = 8'($urandom_range(0, 255));
    end
    gen++;
    w0 = wr_cnt;
    pulse_go();
    #1 chk("done_cleared_on_go", 64'(Done), 64'd0);
    n = 0;
    while (A_Addr[14:8] != 7'd40 && n < 20000) begin
      @(posedge Clk);
      n++;
    end
    repeat (60) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1 chk_reset_vals("reset_mid_run");
    Rst = 1'b1;
    repeat (600) @(posedge Clk);
    #1;
    chk("writes_before_reset", 64'(wr_cnt - w0), 64'd40);
    chk("idle_after_reset", {62'd0, Done, I_En}, 64'd0);

    for (int i = 0; i < 32768; i++) begin
      memA[i] = 8'($urandom_range(0, 255));
      memB[i] = 8'($urandom_range(0, 255));
    end
    run_full(1'b0, cyc);
    chk("done_cycle_rerun", 64'(cyc), 64'd33025);
    chk_results(1'b0);
    chk("b_addr_tracks_a", 64'(addr_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
